// File: rtl/seg_display_scan_if.sv
// Display-side bundle: button and inference inputs in, multiplexed segment/anode pins out.
interface seg_display_scan_if #(
    parameter int unsigned NUM_DIGITS = 4
);
    logic                      btn;
    logic [3:0]                digit;
    logic [4*NUM_DIGITS-1:0]   confidence;
    logic [6:0]                seg;
    logic [NUM_DIGITS-1:0]     an;
    logic                      mode;

    modport master (output btn, digit, confidence, input seg, an, mode);
    modport slave  (input btn, digit, confidence, output seg, an, mode);
endinterface

// File: rtl/seg_display_scan.sv
// Time-multiplexed N-digit seven-segment driver: hex confidence or predicted class,
// with debounced mode toggle, inter-digit blanking and per-frame input latching.
module seg_display_scan #(
    parameter int unsigned NUM_DIGITS      = 4,
    parameter int unsigned REFRESH_DIV     = 100000,
    parameter int unsigned BLANK_CYCLES    = 1000,
    parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
    input  logic               clk,
    input  logic               rst,
    seg_display_scan_if.slave  disp
);
    localparam int unsigned DIV_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned CONF_W = 4 * NUM_DIGITS;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0: hex7 = 7'b1000000;
            4'h1: hex7 = 7'b1111001;
            4'h2: hex7 = 7'b0100100;
            4'h3: hex7 = 7'b0110000;
            4'h4: hex7 = 7'b0011001;
            4'h5: hex7 = 7'b0010010;
            4'h6: hex7 = 7'b0000010;
            4'h7: hex7 = 7'b1111000;
            4'h8: hex7 = 7'b0000000;
            4'h9: hex7 = 7'b0010000;
            4'hA: hex7 = 7'b0001000;
            4'hB: hex7 = 7'b0000011;
            4'hC: hex7 = 7'b1000110;
            4'hD: hex7 = 7'b0100001;
            4'hE: hex7 = 7'b0000110;
            default: hex7 = 7'b0001110;
        endcase
    endfunction

    logic                   btn_meta_q, btn_meta_d;
    logic                   btn_sync_q, btn_sync_d;
    logic                   btn_stable_q, btn_stable_d;
    logic                   stable_prev_q, stable_prev_d;
    logic [DB_W-1:0]        db_cnt_q, db_cnt_d;
    logic                   mode_req_q, mode_req_d;
    logic [DIV_W-1:0]       div_q, div_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [CONF_W-1:0]      frame_conf_q, frame_conf_d;
    logic [3:0]             frame_digit_q, frame_digit_d;
    logic                   frame_mode_q, frame_mode_d;
    logic [NUM_DIGITS-1:0]  an_q, an_d;
    logic [6:0]             seg_q, seg_d;
    logic                   mode_q, mode_d;
    logic [3:0]             nibble;

    always_comb begin
        btn_meta_d    = disp.btn;
        btn_sync_d    = btn_meta_q;
        btn_stable_d  = btn_stable_q;
        stable_prev_d = btn_stable_q;
        db_cnt_d      = '0;
        mode_req_d    = mode_req_q;
        div_d         = div_q + DIV_W'(1);
        idx_d         = idx_q;
        frame_conf_d  = frame_conf_q;
        frame_digit_d = frame_digit_q;
        frame_mode_d  = frame_mode_q;
        an_d          = '1;
        seg_d         = 7'b1111111;
        mode_d        = frame_mode_q;
        nibble        = 4'h0;

        // Accept a new button level only after it has held for the full debounce window
        if (btn_sync_q != btn_stable_q) begin
            if (db_cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                btn_stable_d = btn_sync_q;
            end else begin
                db_cnt_d = db_cnt_q + DB_W'(1);
            end
        end
        if (btn_stable_q && !stable_prev_q) begin
            mode_req_d = ~mode_req_q;
        end

        if (div_q == DIV_W'(REFRESH_DIV - 1)) begin
            div_d = '0;
            idx_d = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
        end

        // Frame boundary: freeze everything the display shows for the coming frame
        if (idx_q == '0 && div_q == '0) begin
            frame_conf_d  = disp.confidence;
            frame_digit_d = disp.digit;
            frame_mode_d  = mode_req_q;
        end

        for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
            if (idx_q == IDX_W'(k)) begin
                nibble = frame_conf_q[4*k +: 4];
            end
        end

        if (div_q >= DIV_W'(BLANK_CYCLES)) begin
            if (!frame_mode_q) begin
                an_d  = ~(NUM_DIGITS'(1) << idx_q);
                seg_d = hex7(nibble);
            end else if (idx_q == '0) begin
                an_d  = ~NUM_DIGITS'(1);
                seg_d = hex7(frame_digit_q);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            btn_meta_q    <= 1'b0;
            btn_sync_q    <= 1'b0;
            btn_stable_q  <= 1'b0;
            stable_prev_q <= 1'b0;
            db_cnt_q      <= '0;
            mode_req_q    <= 1'b0;
            div_q         <= '0;
            idx_q         <= '0;
            frame_conf_q  <= '0;
            frame_digit_q <= 4'h0;
            frame_mode_q  <= 1'b0;
            an_q          <= '1;
            seg_q         <= 7'b1111111;
            mode_q        <= 1'b0;
        end else begin
            btn_meta_q    <= btn_meta_d;
            btn_sync_q    <= btn_sync_d;
            btn_stable_q  <= btn_stable_d;
            stable_prev_q <= stable_prev_d;
            db_cnt_q      <= db_cnt_d;
            mode_req_q    <= mode_req_d;
            div_q         <= div_d;
            idx_q         <= idx_d;
            frame_conf_q  <= frame_conf_d;
            frame_digit_q <= frame_digit_d;
            frame_mode_q  <= frame_mode_d;
            an_q          <= an_d;
            seg_q         <= seg_d;
            mode_q        <= mode_d;
        end
    end

    assign disp.an   = an_q;
    assign disp.seg  = seg_q;
    assign disp.mode = mode_q;

endmodule
